// File: rtl/loader_pkg.sv
// loader_pkg: shared FSM encodings, header offsets and defaults for rom_loader.
package loader_pkg;
    typedef enum logic [1:0] {LD_IDLE, LD_LOAD, LD_FLUSH} ld_state_t;
    typedef enum logic {WR_IDLE, WR_WAIT} wr_state_t;

    localparam logic [31:0] HDR_CKSUM_OFS   = 32'h0000_018E;
    localparam logic [31:0] CKSUM_START_OFS = 32'h0000_0200;
    localparam logic [7:0]  DEFAULT_PAD_BYTE = 8'hFF;

    // Offsets are byte addresses; the write engine works in word addresses.
    function automatic logic is_hdr_word(input logic [31:0] waddr);
        return waddr == (HDR_CKSUM_OFS >> 1);
    endfunction

    function automatic logic in_sum_region(input logic [31:0] waddr);
        return waddr >= (CKSUM_START_OFS >> 1);
    endfunction
endpackage

// File: rtl/loader_fifo.sv
// loader_fifo: show-ahead byte FIFO; a push while full is accepted only when a pop frees a slot that cycle.
module loader_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end

    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
endmodule

// File: rtl/rom_loader.sv
// rom_loader: packs the UART ROM byte stream into big-endian 16-bit SDRAM writes over a toggle req/ack handshake.
// Define ROM_CHECKSUM_EN to compare the header checksum against the sum of image words from 0x200 up.
module rom_loader
    import loader_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         ADDR_W     = 22,
    parameter logic [7:0] PAD_BYTE   = DEFAULT_PAD_BYTE
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [7:0]        rom_loading,
    input  logic [7:0]        rom_do,
    input  logic              rom_do_valid,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              loading,
    output logic              done,
    output logic [ADDR_W:0]   rom_size,
    output logic              overflow,
    output logic              cksum_ok
);
    ld_state_t       ld_state, ld_next;
    wr_state_t       wr_state, wr_next;
    logic            nz_r, pending, fire;
    logic [7:0]      hi, dout;
    logic [ADDR_W:0] byte_cnt;
    logic [15:0]     word;
    logic            push, pop, full, empty, idle_wr, acked, start, pad, issue, finish;

    loader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .din    (rom_do),
        .pop    (pop),
        .dout   (dout),
        .full   (full),
        .empty  (empty)
    );

    // fire delays the req toggle one cycle so mem_addr/mem_din are settled before the request.
    always_comb begin
        start   = ld_state == LD_IDLE && nz_r;
        idle_wr = wr_state == WR_IDLE && mem_req == mem_ack;
        acked   = wr_state == WR_WAIT && !fire && mem_req == mem_ack;
        push    = ld_state == LD_LOAD && rom_do_valid;
        pop     = ld_state != LD_IDLE && idle_wr && !empty;
        pad     = ld_state == LD_FLUSH && idle_wr && empty && pending;
        finish  = ld_state == LD_FLUSH && idle_wr && empty && !pending;
        issue   = (pop && pending) || pad;
        word    = {hi, pad ? PAD_BYTE : dout};
        ld_next = start ? LD_LOAD :
                  (ld_state == LD_LOAD && !nz_r) ? LD_FLUSH :
                  finish ? LD_IDLE : ld_state;
        wr_next = issue ? WR_WAIT : acked ? WR_IDLE : wr_state;
    end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            ld_state <= LD_IDLE;
            wr_state <= WR_IDLE;
        end else begin
            ld_state <= ld_next;
            wr_state <= wr_next;
        end

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            nz_r     <= 1'b0;
            byte_cnt <= '0;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_req  <= 1'b0;
            hi       <= '0;
            pending  <= 1'b0;
            fire     <= 1'b0;
            loading  <= 1'b0;
            done     <= 1'b0;
            rom_size <= '0;
            overflow <= 1'b0;
        end else begin
            nz_r <= rom_loading != 8'd0;
            done <= finish;
            fire <= issue;
            if (fire) mem_req <= ~mem_req;
            if (start) begin
                byte_cnt <= '0;
                mem_addr <= '0;
                pending  <= 1'b0;
                overflow <= 1'b0;
                loading  <= 1'b1;
            end else begin
                if (push) byte_cnt <= byte_cnt + 1'b1;
                if (push && full && !pop) overflow <= 1'b1;
                if (acked) mem_addr <= mem_addr + 1'b1;
                if (pop && !pending) begin
                    hi      <= dout;
                    pending <= 1'b1;
                end
                if (issue) begin
                    mem_din <= word;
                    pending <= 1'b0;
                end
                if (finish) begin
                    rom_size <= byte_cnt;
                    loading  <= 1'b0;
                end
            end
        end

`ifdef ROM_CHECKSUM_EN
    logic [15:0] hdr, sum;

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            hdr      <= '0;
            sum      <= '0;
            cksum_ok <= 1'b0;
        end else if (start) begin
            hdr <= '0;
            sum <= '0;
        end else begin
            if (issue && is_hdr_word(32'(mem_addr))) hdr <= word;
            if (issue && in_sum_region(32'(mem_addr))) sum <= sum + word;
            if (finish) cksum_ok <= sum == hdr;
        end
`else
    assign cksum_ok = 1'b0;
`endif
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed scenarios for rom_loader against a toggle-ack memory with programmable latency.
module tb_rom_loader;
    localparam int ADDR_W = 22;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [7:0]        rom_loading = '0;
    logic [7:0]        rom_do = '0;
    logic              rom_do_valid = 1'b0;
    logic              mem_req;
    logic              mem_ack = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              loading, done, overflow, cksum_ok;
    logic [ADDR_W:0]   rom_size;

    int n_checks = 0;
    int n_fail = 0;
    int ack_delay = 3;
    int done_cnt = 0;
    logic [ADDR_W-1:0] wa[$];
    logic [15:0]       wd[$];

    rom_loader #(.FIFO_DEPTH(16), .ADDR_W(ADDR_W), .PAD_BYTE(8'hFF)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rom_loading  (rom_loading),
        .rom_do       (rom_do),
        .rom_do_valid (rom_do_valid),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .loading      (loading),
        .done         (done),
        .rom_size     (rom_size),
        .overflow     (overflow),
        .cksum_ok     (cksum_ok)
    );

    always #5 clk = ~clk;

    // Memory side: echoes mem_req onto mem_ack after ack_delay cycles.
    initial begin : mem_model
        int cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_req != mem_ack) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack = mem_req;
                    cnt = 0;
                end
            end else cnt = 0;
        end
    end

    // Logs every write request and counts done pulses.
    initial begin : monitor
        logic prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) prev = 1'b0;
            else begin
                if (mem_req != prev) begin
                    wa.push_back(mem_addr);
                    wd.push_back(mem_din);
                    prev = mem_req;
                end
                if (done) done_cnt++;
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic start_load();
        @(negedge clk);
        wa.delete();
        wd.delete();
        rom_loading = 8'h01;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rom_do = b;
        rom_do_valid = 1'b1;
        @(negedge clk);
        rom_do_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic stop_wait(output bit ok);
        int d0;
        d0 = done_cnt;
        rom_loading = 8'h00;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        n_checks++;
        if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_checks++;
        if (mem_din !== 16'h0) begin n_fail++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
        n_checks++;
        if (loading !== 1'b0) begin n_fail++; $display("FAIL reset_loading: got %b want 0", loading); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++;
        if (rom_size !== '0) begin n_fail++; $display("FAIL reset_rom_size: got %h want 0", rom_size); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_checks++;
        if (cksum_ok !== 1'b0) begin n_fail++; $display("FAIL reset_cksum_ok: got %b want 0", cksum_ok); end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({mem_req, loading, done} !== 3'b000) begin n_fail++; $display("FAIL post_reset_idle: got %b want 000", {mem_req, loading, done}); end
    endtask

    task automatic test_basic();
        bit ok;
        int d0;
        logic [15:0] exp_d;
        ack_delay = 3;
        start_load();
        n_checks++;
        if (loading !== 1'b1) begin n_fail++; $display("FAIL basic_loading_high: got %b want 1", loading); end
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) send_byte(8'(i), 0);
        stop_wait(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no done want done"); end
        repeat (3) @(negedge clk);
        n_checks++;
        if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want %0d", done_cnt - d0, 1); end
        n_checks++;
        if (wa.size() !== 4) begin n_fail++; $display("FAIL basic_write_count: got %0d want 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            exp_d = {8'(2 * i), 8'(2 * i + 1)};
            n_checks++;
            if ((i < wa.size() ? wa[i] : 'x) !== ADDR_W'(i) || (i < wd.size() ? wd[i] : 'x) !== exp_d) begin
                n_fail++;
                $display("FAIL basic_write%0d: got addr %h din %h want addr %h din %h", i,
                         i < wa.size() ? wa[i] : 'x, i < wd.size() ? wd[i] : 'x, ADDR_W'(i), exp_d);
            end
        end
        n_checks++;
        if (rom_size !== 23'd8) begin n_fail++; $display("FAIL basic_rom_size: got %0d want 8", rom_size); end
        n_checks++;
        if (loading !== 1'b0) begin n_fail++; $display("FAIL basic_loading_low: got %b want 0", loading); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b want 0", overflow); end
`ifndef ROM_CHECKSUM_EN
        n_checks++;
        if (cksum_ok !== 1'b0) begin n_fail++; $display("FAIL basic_cksum_tied: got %b want 0", cksum_ok); end
`endif
    endtask

    task automatic test_odd();
        bit ok;
        logic [7:0]  bytes[5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        logic [15:0] exp_d[3] = '{16'hA1B2, 16'hC3D4, 16'hE5FF};
        ack_delay = 2;
        start_load();
        foreach (bytes[i]) send_byte(bytes[i], 1);
        stop_wait(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL odd_done_timeout: got no done want done"); end
        n_checks++;
        if (wa.size() !== 3) begin n_fail++; $display("FAIL odd_write_count: got %0d want 3", wa.size()); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ((i < wa.size() ? wa[i] : 'x) !== ADDR_W'(i) || (i < wd.size() ? wd[i] : 'x) !== exp_d[i]) begin
                n_fail++;
                $display("FAIL odd_write%0d: got addr %h din %h want addr %h din %h", i,
                         i < wa.size() ? wa[i] : 'x, i < wd.size() ? wd[i] : 'x, ADDR_W'(i), exp_d[i]);
            end
        end
        n_checks++;
        if (rom_size !== 23'd5) begin n_fail++; $display("FAIL odd_rom_size: got %0d want 5", rom_size); end
    endtask

    task automatic test_overflow();
        bit ok;
        ack_delay = 40;
        start_load();
        for (int i = 0; i < 20; i++) send_byte(8'h20 + 8'(i), 0);
        stop_wait(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ovf_done_timeout: got no done want done"); end
        n_checks++;
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_checks++;
        if (rom_size !== 23'd20) begin n_fail++; $display("FAIL ovf_rom_size: got %0d want 20", rom_size); end
    endtask

    task automatic test_no_overflow();
        bit ok;
        logic [15:0] exp_d;
        ack_delay = 10;
        start_load();
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL noovf_cleared_on_start: got %b want 0", overflow); end
        for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i), 0);
        stop_wait(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL noovf_done_timeout: got no done want done"); end
        n_checks++;
        if (overflow !== 1'b0) begin n_fail++; $display("FAIL noovf_flag: got %b want 0", overflow); end
        n_checks++;
        if (wa.size() !== 10) begin n_fail++; $display("FAIL noovf_write_count: got %0d want 10", wa.size()); end
        for (int i = 0; i < 10; i++) begin
            exp_d = {8'h40 + 8'(2 * i), 8'h41 + 8'(2 * i)};
            n_checks++;
            if ((i < wa.size() ? wa[i] : 'x) !== ADDR_W'(i) || (i < wd.size() ? wd[i] : 'x) !== exp_d) begin
                n_fail++;
                $display("FAIL noovf_write%0d: got addr %h din %h want addr %h din %h", i,
                         i < wa.size() ? wa[i] : 'x, i < wd.size() ? wd[i] : 'x, ADDR_W'(i), exp_d);
            end
        end
        n_checks++;
        if (rom_size !== 23'd20) begin n_fail++; $display("FAIL noovf_rom_size: got %0d want 20", rom_size); end
    endtask

    task automatic test_zero_length();
        bit ok;
        logic r0;
        ack_delay = 3;
        r0 = mem_req;
        start_load();
        stop_wait(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL zero_done_timeout: got no done want done"); end
        n_checks++;
        if (rom_size !== '0) begin n_fail++; $display("FAIL zero_rom_size: got %0d want 0", rom_size); end
        n_checks++;
        if (mem_req !== r0 || wa.size() !== 0) begin
            n_fail++;
            $display("FAIL zero_no_write: got req %b writes %0d want req %b writes 0", mem_req, wa.size(), r0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        ack_delay = 3;
        start_load();
        for (int i = 0; i < 8; i++) send_byte(8'h80 + 8'(i), 0);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (wa.size() >= 3) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL midrst_three_writes: got %0d writes want 3", wa.size()); end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, mem_addr, mem_din, loading, done, rom_size, overflow, cksum_ok} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got req %b addr %h din %h ld %b done %b size %h ovf %b ck %b want all 0",
                     mem_req, mem_addr, mem_din, loading, done, rom_size, overflow, cksum_ok);
        end
        rom_loading = 8'h00;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        start_load();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        send_byte(8'h44, 0);
        stop_wait(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL midrst_done_timeout: got no done want done"); end
        n_checks++;
        if (wa.size() !== 2) begin n_fail++; $display("FAIL midrst_write_count: got %0d want 2", wa.size()); end
        n_checks++;
        if ((wa.size() > 0 ? wa[0] : 'x) !== '0 || (wd.size() > 0 ? wd[0] : 'x) !== 16'h1122) begin
            n_fail++;
            $display("FAIL midrst_write0: got addr %h din %h want addr 0 din 1122",
                     wa.size() > 0 ? wa[0] : 'x, wd.size() > 0 ? wd[0] : 'x);
        end
        n_checks++;
        if ((wa.size() > 1 ? wa[1] : 'x) !== ADDR_W'(1) || (wd.size() > 1 ? wd[1] : 'x) !== 16'h3344) begin
            n_fail++;
            $display("FAIL midrst_write1: got addr %h din %h want addr 1 din 3344",
                     wa.size() > 1 ? wa[1] : 'x, wd.size() > 1 ? wd[1] : 'x);
        end
        n_checks++;
        if (rom_size !== 23'd4) begin n_fail++; $display("FAIL midrst_rom_size: got %0d want 4", rom_size); end
    endtask

`ifdef ROM_CHECKSUM_EN
    function automatic logic [7:0] img_byte(input int i, input logic [7:0] last);
        case (i)
            'h100: return 8'h55;
            'h18E: return 8'h12;
            'h18F: return 8'h34;
            'h200: return 8'h10;
            'h202: return 8'h02;
            'h203: return last;
            default: return 8'h00;
        endcase
    endfunction

    task automatic test_checksum();
        bit ok;
        logic [7:0] last[2] = '{8'h34, 8'h35};
        logic       exp_ok[2] = '{1'b1, 1'b0};
        ack_delay = 1;
        for (int r = 0; r < 2; r++) begin
            start_load();
            for (int i = 0; i < 'h204; i++) send_byte(img_byte(i, last[r]), 2);
            stop_wait(ok);
            n_checks++;
            if (!ok) begin n_fail++; $display("FAIL cksum%0d_done_timeout: got no done want done", r); end
            n_checks++;
            if (cksum_ok !== exp_ok[r]) begin n_fail++; $display("FAIL cksum%0d_ok: got %b want %b", r, cksum_ok, exp_ok[r]); end
            n_checks++;
            if (rom_size !== 23'h204) begin n_fail++; $display("FAIL cksum%0d_rom_size: got %h want 204", r, rom_size); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_overflow();
        test_no_overflow();
        test_zero_length();
        test_reset_mid();
`ifdef ROM_CHECKSUM_EN
        test_checksum();
`endif
        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
